// File: rtl/mem_arb.sv
// Arbitrates instruction fetch and load/store onto one registered memory port; LS wins unless IF starved.
// Latency: grant is combinational in IDLE, memory request registered the next cycle, completion on mem_ack.
// Backpressure: requesters hold req until their grant; only IDLE grants, so a busy port stalls both sides.
module mem_arb #(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [31:0]   ls_wdata,
    input  logic [3:0]    ls_be,
    output logic          ls_gnt,
    output logic          ls_done,
    output logic [31:0]   ls_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        IF_WAIT,
        LS_WAIT
    } state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
    } mem_cmd_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    mem_cmd_t      cmd_q, cmd_d;
    logic          if_forced;

    // IF takes the port only once LS has been granted STARVE_MAX times in a row over it
    assign if_forced = if_req && (starve_cnt == STARVE_LIM);

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        cmd_d      = cmd_q;
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (ls_req && !if_forced) begin
                        ls_gnt    = 1'b1;
                        state_nxt = LS_WAIT;
                        cmd_d     = '{we: ls_we, addr: ls_addr, wdata: ls_wdata, be: ls_be};
                        if (!if_req)
                            starve_nxt = '0;
                        else if (starve_cnt != STARVE_LIM)
                            starve_nxt = starve_cnt + SW'(1);
                    end else if (if_req) begin
                        if_gnt     = 1'b1;
                        state_nxt  = IF_WAIT;
                        cmd_d      = '{we: 1'b0, addr: if_addr, wdata: 32'h0, be: 4'hF};
                        starve_nxt = '0;
                    end
                end
            end
            IF_WAIT, LS_WAIT: begin
                if (mem_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            cmd_q      <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            mem_req    <= (state_nxt != IDLE);
            cmd_q      <= cmd_d;
        end
    end

    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_be    = cmd_q.be;
    assign busy      = (state != IDLE);

    // mem_ack outside a wait state is ignored; store completions return zero data
    assign if_rvalid = (state == IF_WAIT) && mem_ack;
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign ls_done   = (state == LS_WAIT) && mem_ack;
    assign ls_rdata  = (ls_done && !cmd_q.we) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios with a completion scoreboard fed by a latency-programmable memory responder.
module tb_mem_arb;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_done;
    logic [AW-1:0] ls_addr;
    logic [31:0]   ls_wdata, ls_rdata;
    logic [3:0]    ls_be;
    logic          mem_req, mem_we, mem_ack, busy;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_be;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   resp_en = 1'b0;
    int   ack_lat = 1;
    int   wcnt = 0;

    mem_arb #(.STARVE_MAX(4), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return a * 32'd3 + 32'h1234_0001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks after ack_lat cycles of mem_req, always returning model data
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    wcnt    = 0;
                end else if (mem_req) begin
                    wcnt++;
                    if (wcnt >= ack_lat) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_model(mem_addr);
                        wcnt      = 0;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    // Completion monitor and grant-legality checks
    always @(negedge clk) begin
        if (!rst) begin
            if (if_gnt || ls_gnt) begin
                checks++;
                if ((if_gnt && ls_gnt) || busy) begin
                    errors++;
                    $display("FAIL grant_legal: if_gnt=%0b ls_gnt=%0b busy=%0b, need one grant and busy=0",
                             if_gnt, ls_gnt, busy);
                end
            end
            if (if_rvalid || ls_done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL completion_spurious: if_rvalid=%0b ls_done=%0b with nothing outstanding",
                             if_rvalid, ls_done);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.is_if != if_rvalid ||
                        (if_rvalid ? if_rdata : ls_rdata) !== mon_e.data) begin
                        errors++;
                        $display("FAIL completion: got is_if=%0b data=%h, expected is_if=%0b data=%h",
                                 if_rvalid, (if_rvalid ? if_rdata : ls_rdata), mon_e.is_if, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, busy, if_rvalid, ls_done, mem_be} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req/we/busy/rvalid/done/be=%b, expected all 0",
                     {mem_req, mem_we, busy, if_rvalid, ls_done, mem_be});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, ls_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h ls_rdata=%h, expected 0",
                     mem_addr, mem_wdata, if_rdata, ls_rdata);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        resp_en = 1'b1;
        ack_lat = 2;
        if_addr = 32'h100;
        if_req  = 1'b1;
        sb.push_back('{1'b1, 32'h13});
        @(negedge clk);
        checks++;
        if ({if_gnt, ls_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_gnt: if_gnt/ls_gnt=%b, expected 10", {if_gnt, ls_gnt});
        end
        tick();
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_be, if_rvalid} !== 7'b1011110 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL fetch_cmd: req/we/be/rvalid=%b addr=%h, expected 1011110 addr=00000100",
                     {mem_req, mem_we, mem_be, if_rvalid}, mem_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({mem_req, if_rvalid} !== 2'b11 || if_rdata !== 32'h13) begin
            errors++;
            $display("FAIL fetch_rvalid: req/rvalid=%b rdata=%h, expected 11 rdata=00000013",
                     {mem_req, if_rvalid}, if_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_release: req/busy=%b, expected 00", {mem_req, busy});
        end
        tick();
    endtask

    task automatic test_priority();
        ack_lat  = 1;
        if_addr  = 32'h300;
        ls_addr  = 32'h200;
        ls_we    = 1'b0;
        if_req   = 1'b1;
        ls_req   = 1'b1;
        sb.push_back('{1'b0, mem_model(32'h200)});
        sb.push_back('{1'b1, mem_model(32'h300)});
        @(negedge clk);
        checks++;
        if ({if_gnt, ls_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL prio_first: if_gnt/ls_gnt=%b, expected 01", {if_gnt, ls_gnt});
        end
        tick();
        ls_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({ls_done, if_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL prio_done: ls_done/if_gnt=%b, expected 10", {ls_done, if_gnt});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({if_gnt, ls_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL prio_second: if_gnt/ls_gnt=%b, expected 10", {if_gnt, ls_gnt});
        end
        tick();
        if_req = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_starve();
        bit exp_if[7] = '{0, 0, 0, 0, 1, 0, 1};
        int nls = 0;
        int nif = 0;
        bit got;
        bit gi;
        ack_lat = 1;
        for (int g = 0; g < 7; g++)
            if (exp_if[g]) sb.push_back('{1'b1, mem_model(32'h400 + 32'(4 * nif++))});
            else           sb.push_back('{1'b0, mem_model(32'h500 + 32'(4 * nls++))});
        nls     = 0;
        nif     = 0;
        if_addr = 32'h400;
        ls_addr = 32'h500;
        ls_we   = 1'b0;
        if_req  = 1'b1;
        ls_req  = 1'b1;
        for (int g = 0; g < 7; g++) begin
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (if_gnt || ls_gnt) got = 1'b1;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL starve_grant%0d: no grant within 10 cycles", g);
                break;
            end
            checks++;
            if (if_gnt !== exp_if[g]) begin
                errors++;
                $display("FAIL starve_order%0d: if_gnt=%0b ls_gnt=%0b, expected if_gnt=%0b",
                         g, if_gnt, ls_gnt, exp_if[g]);
            end
            gi = if_gnt;
            tick();
            if (gi) begin
                nif++;
                if (nif < 2) if_addr = 32'h400 + 32'(4 * nif);
                else         if_req = 1'b0;
            end else begin
                nls++;
                if (nls < 5) ls_addr = 32'h500 + 32'(4 * nls);
                else         ls_req = 1'b0;
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        for (int c = 0; c < 10 && busy; c++) @(negedge clk);
        tick();
    endtask

    task automatic test_store();
        bit done = 1'b0;
        ack_lat  = 3;
        ls_addr  = 32'h600;
        ls_we    = 1'b1;
        ls_be    = 4'b0011;
        ls_wdata = 32'hDEADBEEF;
        ls_req   = 1'b1;
        sb.push_back('{1'b0, 32'h0});
        @(negedge clk);
        checks++;
        if (ls_gnt !== 1'b1) begin
            errors++;
            $display("FAIL store_gnt: ls_gnt=%0b, expected 1", ls_gnt);
        end
        tick();
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_be    = 4'hF;
        ls_wdata = 32'h0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, mem_we, mem_be} !== 6'b110011 || mem_wdata !== 32'hDEADBEEF ||
                mem_addr !== 32'h600) begin
                errors++;
                $display("FAIL store_cmd: req/we/be=%b wdata=%h addr=%h, expected 110011 DEADBEEF 00000600",
                         {mem_req, mem_we, mem_be}, mem_wdata, mem_addr);
            end
            if (ls_done) begin
                done = 1'b1;
                checks++;
                if (ls_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL store_rdata: ls_rdata=%h, expected 0", ls_rdata);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL store_done: ls_done not seen within 8 cycles");
        end
        tick();
    endtask

    task automatic test_abort();
        bit got = 1'b0;
        resp_en = 1'b0;
        ls_addr = 32'h700;
        ls_we   = 1'b0;
        ls_req  = 1'b1;
        @(negedge clk);
        checks++;
        if (ls_gnt !== 1'b1) begin
            errors++;
            $display("FAIL abort_gnt: ls_gnt=%0b, expected 1", ls_gnt);
        end
        tick();
        ls_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, busy} !== 2'b11) begin
            errors++;
            $display("FAIL abort_wait: req/busy=%b, expected 11", {mem_req, busy});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, busy, ls_done} !== 3'b000 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL abort_async: req/busy/done=%b addr=%h, expected 000 addr=0",
                     {mem_req, busy, ls_done}, mem_addr);
        end
        repeat (2) @(negedge clk);
        tick();
        rst     = 1'b0;
        resp_en = 1'b1;
        ack_lat = 1;
        if_addr = 32'h104;
        if_req  = 1'b1;
        sb.push_back('{1'b1, mem_model(32'h104)});
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL abort_regrant: if_gnt=%0b, expected 1 right after reset release", if_gnt);
        end
        tick();
        if_req = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (if_rvalid) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL abort_fetch: if_rvalid not seen within 8 cycles");
        end
        tick();
    endtask

    task automatic test_idle_ack();
        resp_en   = 1'b0;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if ({if_rvalid, ls_done, busy, mem_req} !== 4'b0 || {if_rdata, ls_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL idle_ack: rvalid/done/busy/req=%b if_rdata=%h ls_rdata=%h, expected 0",
                     {if_rvalid, ls_done, busy, mem_req}, if_rdata, ls_rdata);
        end
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, mem_req, if_gnt, ls_gnt} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after: busy/req/if_gnt/ls_gnt=%b, expected 0000",
                     {busy, mem_req, if_gnt, ls_gnt});
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_addr  = '0;
        ls_wdata = '0;
        ls_be    = 4'hF;
        test_reset();
        test_fetch();
        test_priority();
        test_starve();
        test_store();
        test_abort();
        test_idle_ack();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d completions never seen", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
